// File: rtl/self_attention_pkg.sv
// rtl/self_attention_pkg.sv - shared defaults and types for the attention score path
// Purpose: default geometry of the Qn*KnT score block, the score-word type
//          and the drain FSM state encoding used by qk_score_buffer.
// Ports:   none (package)
package self_attention_pkg;

   localparam int DEF_ELEM_W         = 16;
   localparam int DEF_FRAC_W         = 8;
   localparam int DEF_ELEMS_PER_WORD = 2;
   localparam int DEF_NUM_WORDS      = 4;
   localparam int DEF_SCALE_SHIFT    = 3;

   localparam int DEF_WORD_W = DEF_ELEMS_PER_WORD * DEF_ELEM_W;
   localparam int DEF_IDX_W  = (DEF_NUM_WORDS > 1) ? $clog2(DEF_NUM_WORDS) : 1;

   typedef logic [DEF_WORD_W-1:0] score_word_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } drain_state_e;

endpackage

// File: rtl/qk_score_buffer_if.sv
// rtl/qk_score_buffer_if.sv - block-in / word-out handshake bundle of qk_score_buffer
// Purpose: groups the score-block input and the scaled-word output handshakes.
// Ports:   in_valid/in_data/in_ready  score block from the matmul
//          out_data/out_valid/out_ready/out_last/out_idx  scaled words toward softmax
// Modports: slave = the buffer, master = the producer/consumer side.
interface qk_score_buffer_if
   import self_attention_pkg::*;
#(
   parameter int ELEM_W         = DEF_ELEM_W,
   parameter int ELEMS_PER_WORD = DEF_ELEMS_PER_WORD,
   parameter int NUM_WORDS      = DEF_NUM_WORDS
) ();

   localparam int WORD_W = ELEMS_PER_WORD * ELEM_W;
   localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   logic                                in_valid;
   logic [NUM_WORDS-1:0][WORD_W-1:0]    in_data;
   logic                                in_ready;
   logic [WORD_W-1:0]                   out_data;
   logic                                out_valid;
   logic                                out_ready;
   logic                                out_last;
   logic [IDX_W-1:0]                    out_idx;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_data, out_valid, out_last, out_idx
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_idx
   );

endinterface

// File: rtl/score_scale_round.sv
// rtl/score_scale_round.sv - round-to-nearest arithmetic right shift of one score element
// Purpose: scales one signed fixed-point element by 2^-SCALE_SHIFT with rounding.
// Ports:   elem_i  signed element in
//          elem_o  scaled element out (same width, always representable)
module score_scale_round #(
   parameter int ELEM_W      = 16,
   parameter int SCALE_SHIFT = 3
) (
   input  logic [ELEM_W-1:0] elem_i,
   output logic [ELEM_W-1:0] elem_o
);

   localparam logic [ELEM_W:0] ROUND = {{ELEM_W{1'b0}}, 1'b1} << (SCALE_SHIFT - 1);

   // One extra bit keeps the rounding add from wrapping at the positive limit;
   // after the shift the result always fits back into ELEM_W bits.
   logic [ELEM_W:0] sum_w;

   assign sum_w  = {elem_i[ELEM_W-1], elem_i} + ROUND;
   assign elem_o = ELEM_W'($signed(sum_w) >>> SCALE_SHIFT);

endmodule

// File: rtl/qk_score_buffer.sv
// rtl/qk_score_buffer.sv - ping-pong buffer scaling QK^T score blocks and streaming them as words
// Purpose: captures a whole score block in one cycle into one of two banks,
//          scaled by 2^-SCALE_SHIFT, and drains banks word by word in capture order.
// Ports:   clk       sole clock
//          rst       synchronous active-high reset
//          bus       qk_score_buffer_if slave (block in, word out)
//          drop_cnt  saturating count of blocks refused while both banks were full
module qk_score_buffer
   import self_attention_pkg::*;
#(
   parameter int ELEM_W         = DEF_ELEM_W,
   parameter int FRAC_W         = DEF_FRAC_W,
   parameter int ELEMS_PER_WORD = DEF_ELEMS_PER_WORD,
   parameter int NUM_WORDS      = DEF_NUM_WORDS,
   parameter int SCALE_SHIFT    = DEF_SCALE_SHIFT
) (
   input  logic               clk,
   input  logic               rst,
   qk_score_buffer_if.slave   bus,
   output logic [7:0]         drop_cnt
);

   localparam int WORD_W = ELEMS_PER_WORD * ELEM_W;
   localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef logic [NUM_WORDS-1:0][WORD_W-1:0] block_t;

   if (SCALE_SHIFT < 1 || SCALE_SHIFT > ELEM_W - 1 || FRAC_W < 0 || FRAC_W > ELEM_W) begin : g_param_check
      $error("qk_score_buffer: illegal parameter");
   end

   block_t        scaled;
   block_t        bank_q [2];
   logic [1:0]    full_q, full_d;
   logic          rd_q, rd_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]    drop_q, drop_d;
   drain_state_e  state_q, state_d;

   logic wr_bank;
   logic capture;
   logic drop;
   logic out_valid;
   logic xfer;
   logic last_xfer;

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      for (genvar e = 0; e < ELEMS_PER_WORD; e++) begin : g_elem
         score_scale_round #(
            .ELEM_W      (ELEM_W),
            .SCALE_SHIFT (SCALE_SHIFT)
         ) u_scale (
            .elem_i (bus.in_data[w][e*ELEM_W +: ELEM_W]),
            .elem_o (scaled[w][e*ELEM_W +: ELEM_W])
         );
      end
   end

   // Bank 0 is preferred when both are free.
   assign wr_bank   = full_q[0];
   assign capture   = bus.in_valid & bus.in_ready;
   assign drop      = bus.in_valid & ~bus.in_ready;
   assign out_valid = (state_q == ST_STREAM) & full_q[rd_q];
   assign xfer      = out_valid & bus.out_ready;
   assign last_xfer = xfer & (idx_q == LAST_IDX);

   assign bus.in_ready  = ~(&full_q);
   assign bus.out_valid = out_valid;
   assign bus.out_data  = bank_q[rd_q][idx_q];
   assign bus.out_last  = out_valid & (idx_q == LAST_IDX);
   assign bus.out_idx   = idx_q;
   assign drop_cnt      = drop_q;

   always_comb begin
      full_d  = full_q;
      rd_d    = rd_q;
      idx_d   = idx_q;
      drop_d  = drop_q;
      state_d = state_q;

      // A capture never targets the draining bank: it needs a free bank and
      // the draining one is full, so both updates can land on the same edge.
      if (last_xfer) full_d[rd_q]    = 1'b0;
      if (capture)   full_d[wr_bank] = 1'b1;

      if (xfer) idx_d = last_xfer ? '0 : idx_q + 1'b1;

      // With only two banks the next block in capture order is always the
      // other bank; a capture into an empty buffer always lands in bank 0.
      if (last_xfer)
         rd_d = ~rd_q;
      else if (capture && full_q == 2'b00)
         rd_d = 1'b0;

      if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

      case (state_q)
         ST_IDLE:   if (|full_d) state_d = ST_STREAM;
         ST_STREAM: if (last_xfer && !(|full_d)) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q  <= 2'b00;
         rd_q    <= 1'b0;
         idx_q   <= '0;
         drop_q  <= 8'd0;
         state_q <= ST_IDLE;
      end else begin
         full_q  <= full_d;
         rd_q    <= rd_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
         state_q <= state_d;
      end
   end

   // Bank storage is not reset; the full flags alone decide what is valid.
   always_ff @(posedge clk) begin
      if (capture && !rst) bank_q[wr_bank] <= scaled;
   end

endmodule

// File: tb/tb_qk_score_buffer.sv
// tb/tb_qk_score_buffer.sv - self-checking bench for qk_score_buffer
module tb_qk_score_buffer;
   import self_attention_pkg::*;

   localparam int W  = DEF_ELEM_W;
   localparam int E  = DEF_ELEMS_PER_WORD;
   localparam int N  = DEF_NUM_WORDS;
   localparam int S  = DEF_SCALE_SHIFT;
   localparam int WW = W * E;

   typedef logic [N-1:0][WW-1:0] block_t;
   typedef struct {
      logic [WW-1:0] data;
      logic [1:0]    idx;
      logic          last;
   } exp_t;
   typedef struct {
      logic [W-1:0] in0;
      logic [W-1:0] in1;
      logic [W-1:0] ex0;
      logic [W-1:0] ex1;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] drop_cnt;

   always #5 clk = ~clk;

   qk_score_buffer_if bus ();

   qk_score_buffer dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .drop_cnt (drop_cnt)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t sb [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_scale(input logic [W-1:0] x);
      int v;
      v = int'($signed(x)) + (1 << (S - 1));
      v = v >>> S;
      return v[W-1:0];
   endfunction

   // Monitor: pushes expected words on capture, pops on transfer, checks hold.
   logic          hold_v = 1'b0;
   logic [WW-1:0] hold_data;
   logic [1:0]    hold_idx;
   logic          hold_last;
   exp_t          mon_e;
   exp_t          mon_got;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v)
            check("hold_stable", 64'({bus.out_data, bus.out_idx, bus.out_last}),
                  64'({hold_data, hold_idx, hold_last}));
         if (bus.in_valid && bus.in_ready) begin
            for (int w = 0; w < N; w++) begin
               for (int e = 0; e < E; e++)
                  mon_e.data[e*W +: W] = ref_scale(bus.in_data[w][e*W +: W]);
               mon_e.idx  = 2'(w);
               mon_e.last = (w == N - 1);
               sb.push_back(mon_e);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_word", 64'(1), 64'(0));
            end else begin
               mon_e = sb.pop_front();
               mon_got.data = bus.out_data;
               mon_got.idx  = bus.out_idx;
               mon_got.last = bus.out_last;
               check("sb_word", 64'({mon_got.data, mon_got.idx, mon_got.last}),
                     64'({mon_e.data, mon_e.idx, mon_e.last}));
            end
         end
         hold_v    = bus.out_valid && !bus.out_ready;
         hold_data = bus.out_data;
         hold_idx  = bus.out_idx;
         hold_last = bus.out_last;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic drive_block(input block_t b);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic rand_block(output block_t b);
      for (int w = 0; w < N; w++) b[w] = WW'($urandom());
   endtask

   task automatic wait_drain(input bit toggle);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (!bus.out_valid && sb.size() == 0) begin
            done = 1'b1;
            break;
         end
         if (toggle) bus.out_ready = ~bus.out_ready;
         @(posedge clk);
         #1;
      end
      if (!done) check("drain_timeout", 64'(0), 64'(1));
      bus.out_ready = 1'b1;
   endtask

   vec_t   vecs [5];
   block_t blk;
   int     bubbles;
   int     found;
   logic [7:0] drop_before;

   initial begin
      vecs[0] = '{16'h0100, 16'h0004, 16'h0020, 16'h0001};
      vecs[1] = '{16'hFFFC, 16'hFFF4, 16'h0000, 16'hFFFF};
      vecs[2] = '{16'h7FFF, 16'h8000, 16'h1000, 16'hF000};
      vecs[3] = '{16'h0007, 16'hFFF8, 16'h0001, 16'hFFFF};
      vecs[4] = '{16'h0003, 16'h0004, 16'h0000, 16'h0001};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_last",  64'(bus.out_last),  64'(0));
      check("rst_in_ready",  64'(bus.in_ready),  64'(1));
      check("rst_drop_cnt",  64'(drop_cnt),      64'(0));

      // Table vectors: word 0 carries the vector, first word visible right after capture.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_block(blk);
         blk[0] = {vecs[i].in1, vecs[i].in0};
         drive_block(blk);
         check("vec_word0", 64'({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last}),
               64'({1'b1, vecs[i].ex1, vecs[i].ex0, 2'd0, 1'b0}));
         wait_drain(1'b0);
      end

      // Three back-to-back blocks with the sink stalled: third one dropped.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_block(blk);
         drive_block(blk);
      end
      check("b2b_in_ready", 64'(bus.in_ready), 64'(0));
      check("b2b_drop_cnt", 64'(drop_cnt),     64'(1));
      bus.out_ready = 1'b1;
      bubbles = 0;
      for (int i = 0; i < 8; i++) begin
         if (!bus.out_valid) bubbles++;
         @(posedge clk);
         #1;
      end
      check("b2b_bubbles",   64'(bubbles),       64'(0));
      check("b2b_empty",     64'(bus.out_valid), 64'(0));
      check("b2b_sb_empty",  64'(sb.size()),     64'(0));

      // Sink toggling 1010... during one block.
      bus.out_ready = 1'b0;
      rand_block(blk);
      drive_block(blk);
      wait_drain(1'b1);
      check("toggle_sb_empty", 64'(sb.size()), 64'(0));

      // Block arriving on the cycle bank A's last word transfers is dropped.
      bus.out_ready = 1'b0;
      rand_block(blk);
      drive_block(blk);
      rand_block(blk);
      drive_block(blk);
      bus.out_ready = 1'b1;
      found = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.out_valid && bus.out_idx == 2'd3) begin
            found = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("race_found_last", 64'(found),        64'(1));
      check("race_in_ready0",  64'(bus.in_ready), 64'(0));
      drop_before = drop_cnt;
      rand_block(blk);
      drive_block(blk);
      check("race_drop_cnt",   64'(drop_cnt),     64'(drop_before + 8'd1));
      check("race_in_ready1",  64'(bus.in_ready), 64'(1));
      rand_block(blk);
      drive_block(blk);
      check("race_no_drop",    64'(drop_cnt),     64'(drop_before + 8'd1));
      wait_drain(1'b0);

      // Reset in mid-stream, with a block presented alongside reset.
      rand_block(blk);
      drive_block(blk);
      found = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.out_valid && bus.out_idx == 2'd2) begin
            found = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("rst_mid_found", 64'(found), 64'(1));
      rst = 1'b1;
      rand_block(blk);
      bus.in_valid = 1'b1;
      bus.in_data  = blk;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_mid_in_ready",  64'(bus.in_ready),  64'(1));
      check("rst_mid_drop_cnt",  64'(drop_cnt),      64'(0));
      check("rst_mid_out_idx",   64'(bus.out_idx),   64'(0));
      rand_block(blk);
      drive_block(blk);
      check("post_rst_idx0", 64'({bus.out_valid, bus.out_idx}), 64'({1'b1, 2'd0}));
      wait_drain(1'b0);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/qk_score_buffer.md
QK_SCORE_BUFFER -- requirements
Module: qk_score_buffer
Interface
REQ-001 Param ELEM_W, default 16, fixed-point element width of the Qn*KnT matmul output.
REQ-002 Param FRAC_W, default 8, fractional bits; carried through unchanged, no arithmetic effect.
REQ-003 Param ELEMS_PER_WORD, default 2, elements per matmul output word.
REQ-004 Param NUM_WORDS, default 4, words per score block, equal to matmul TOTAL_INPUT_W.
REQ-005 Param SCALE_SHIFT, default 3, right shift implementing 1/sqrt(d_k); legal range 1..ELEM_W-1.
REQ-006 clk  in  1  sole clock; one clock domain; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  score block present on in_data this cycle.
REQ-009 in_data  in  [NUM_WORDS] x ELEMS_PER_WORD*ELEM_W  score block; element e of word w at bits [e*ELEM_W +: ELEM_W].
REQ-010 in_ready  out  1  a free bank exists; derived from registered bank flags only.
REQ-011 out_data  out  ELEMS_PER_WORD*ELEM_W  scaled score word, toward softmax.
REQ-012 out_valid  out  1  out_data valid.
REQ-013 out_ready  in  1  downstream accepts word.
REQ-014 out_last  out  1  out_data is word NUM_WORDS-1 of its block.
REQ-015 out_idx  out  clog2(NUM_WORDS)  word index of out_data.
REQ-016 drop_cnt  out  8  count of blocks rejected because in_valid arrived with in_ready low.
Function
REQ-017 Two banks (ping-pong), each NUM_WORDS words, each with a registered full flag.
REQ-018 Capture: in_valid && in_ready writes all NUM_WORDS scaled words into the free bank in one cycle; full flag set at that edge; bank 0 chosen when both free.
REQ-019 Scaling per element: signed value plus 2^(SCALE_SHIFT-1), computed at ELEM_W+1 bits, then arithmetic right shift by SCALE_SHIFT, truncated to ELEM_W; result always representable, no saturation.
REQ-020 Drain FSM states IDLE, STREAM; IDLE->STREAM when any bank full; STREAM->IDLE when last word accepted and no other bank full; otherwise stays in STREAM, switching to the other full bank with no bubble.
REQ-021 Banks drain in capture order; a registered read pointer identifies the draining bank.
REQ-022 Latency: block captured at edge k with drain idle -> out_valid high after edge k, word 0 presented.
REQ-023 Handshake: word transfers on out_valid && out_ready; out_data/out_idx/out_last held stable while out_valid && !out_ready; out_idx increments per transfer, wraps to 0 after NUM_WORDS-1.
REQ-024 Bank full flag cleared at edge where its out_last word transfers; in_ready reflects the freed bank from the next cycle.
REQ-025 Simultaneous capture and final-word transfer in one cycle: both take effect; the capture uses the other (already free) bank.
REQ-026 in_valid && !in_ready: block discarded, banks untouched, drop_cnt increments, saturates at 255.
REQ-027 out_valid low whenever no bank is full.
Reset
REQ-028 rst high at any edge, including mid-capture or mid-stream: both full flags 0, FSM IDLE, read pointer bank 0, out_idx 0, drop_cnt 0.
REQ-029 After reset: out_valid 0, out_last 0, in_ready 1; out_data don't-care but driven; bank contents not cleared.
REQ-030 in_valid coincident with rst is ignored and not counted.
Structure
REQ-031 ELEM_W, FRAC_W, ELEMS_PER_WORD, NUM_WORDS, SCALE_SHIFT defaults and the score-word typedef live in self_attention_pkg.
REQ-032 One combinational sub-module score_scale_round (one element: round, shift) instantiated ELEMS_PER_WORD*NUM_WORDS times.
Verification (defaults)
REQ-033 Word 0 elements {0x0100, 0x0004} captured, out_ready=1 -> next cycle out_data {0x0020, 0x0001}, out_idx 0, out_last 0.
REQ-034 Elements 0xFFFC, 0xFFF4, 0x7FFF, 0x8000 -> 0x0000, 0xFFFF, 0x1000, 0xF000.
REQ-035 Three blocks back-to-back, out_ready=0 -> blocks 1,2 captured, in_ready 0, block 3 dropped, drop_cnt 1; then out_ready=1 -> 8 words block1 then block2, out_last on idx 3 and 7 overall, no bubble.
REQ-036 out_ready toggling 1010... during one block -> each word held stable until accepted, order 0..3.
REQ-037 Both banks full, block arrives same cycle as bank-A out_last transfer -> block dropped (in_ready was 0), drop_cnt increments; block arriving next cycle captured into bank A.
REQ-038 rst asserted at out_idx 2 -> next cycle out_valid 0, in_ready 1, drop_cnt 0; new block then streams from idx 0.
